// File: rtl/clk_pwm_pkg.sv
// rtl/clk_pwm_pkg.sv - shared types, default width and config clamp helpers for clk_pwm_gen
package clk_pwm_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } pwm_state_e;

    // Periods below 2 cannot produce a distinct tick cycle, so they are raised to 2.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'd2) ? 32'd2 : p;
    endfunction

    // A high time beyond the period behaves as constant high; store it capped at P.
    function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] p);
        return (h > p) ? p : h;
    endfunction

endpackage

// File: rtl/clk_pwm_gen.sv
// rtl/clk_pwm_gen.sv - programmable period/duty pulse generator with period tick
// Settings go through a pending register and take effect only at period boundaries.
module clk_pwm_gen
    import clk_pwm_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             period_tick,
    output logic             busy
);

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pend_q, pend_d;
    logic             applied_q, applied_d;
    logic             ready_q, ready_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             last;
    logic             apply;
    logic             run_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        high_d      = high_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        pend_d      = pend_q;
        applied_d   = 1'b0;
        ready_d     = ready_q;
        apply       = 1'b0;
        last        = (cnt_q == per_q - CNT_W'(1));

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                apply = pend_q;
                if (en) state_d = RUN;
            end
            RUN: begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                apply = pend_q && last;
                if (!en) state_d = STOP_PEND;
            end
            STOP_PEND: begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                apply = pend_q && last;
                if (en)        state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (apply) begin
            per_d     = CNT_W'(clamp_period(32'(pend_per_q)));
            high_d    = CNT_W'(clamp_high(32'(pend_high_q), 32'(per_d)));
            pend_d    = 1'b0;
            applied_d = 1'b1;
        end

        if (applied_q) ready_d = 1'b1;

        // ready_q is only high with nothing pending, so capture never races an apply.
        if (cfg_valid && ready_q) begin
            pend_per_d  = cfg_period;
            pend_high_d = cfg_high;
            pend_d      = 1'b1;
            ready_d     = 1'b0;
        end

        run_d     = (state_d != IDLE);
        clk_out_d = run_d && (cnt_d < high_d);
        tick_d    = run_d && (cnt_d == per_d - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_q       <= CNT_W'(DEF_PERIOD);
            high_q      <= CNT_W'(DEF_HIGH);
            pend_per_q  <= '0;
            pend_high_q <= '0;
            pend_q      <= 1'b0;
            applied_q   <= 1'b0;
            ready_q     <= 1'b1;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            high_q      <= high_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pend_q      <= pend_d;
            applied_q   <= applied_d;
            ready_q     <= ready_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign clk_out     = clk_out_q;
    assign period_tick = tick_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/clk_pwm_gen.md
# clk_pwm_gen

Programmable period/duty clock-pulse generator fed by the on-chip high-frequency oscillator (SB_HFOSC) clock domain. It sits directly downstream of the oscillator and produces a divided output with a programmable high time, such as the 30 % duty waveform used on the divided-clock bench. It also produces a one-cycle end-of-period tick for downstream timers. New settings are applied glitch-free at period boundaries through a valid/ready handshake.

## Interface
- CNT_W, 16: width of counter, period and high-time fields
- DEF_PERIOD, 10: period (in clk cycles) loaded at reset
- DEF_HIGH, 3: high time (in clk cycles) loaded at reset
- clk  in  1  oscillator clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  generator can accept a configuration
- cfg_period  in  CNT_W  requested period, in cycles
- cfg_high  in  CNT_W  requested high time, in cycles
- clk_out  out  1  generated waveform (registered)
- period_tick  out  1  high during the last cycle of each period (registered)
- busy  out  1  high while in RUN or STOP_PEND

## Operation
- States:
  - IDLE: counter held at 0, clk_out = 0.
  - RUN: counting.
  - STOP_PEND: counting, exit at period end.
- IDLE→RUN when en = 1. RUN→STOP_PEND when en = 0. STOP_PEND→IDLE on the last cycle of the period. STOP_PEND→RUN if en = 1 again; the count is not disturbed.
- Counter cnt runs 0..P-1 and wraps to 0, where P is the active period.
- clk_out = (cnt < H), where H is the active high time. Width-compare is unsigned at CNT_W.
- Clamping when configuration is applied: P < 2 becomes 2. H ≥ P gives constant high for the period. H = 0 gives constant low.
- Config handshake: transfer occurs when cfg_valid && cfg_ready. Values go into a pending register, and cfg_ready drops to 0.
- Pending config becomes active in two cases:
  - in IDLE, on the next cycle;
  - in RUN or STOP_PEND, at the wrap from P-1 to 0, provided it was captured before the boundary cycle. A capture made in the boundary cycle waits for the following boundary.
- cfg_ready returns to 1 in the cycle after the pending config becomes active.
- busy = (state ≠ IDLE).

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - clk_out = 0, period_tick = 0, busy = 0, cfg_ready = 1.
  - Active P = DEF_PERIOD, active H = DEF_HIGH, no config pending.
- Start: en sampled 1 in IDLE at edge k. At edge k+1, cnt = 0 and clk_out = (H > 0). Latency is 1 cycle.
- cnt and clk_out update on the same edge, so clk_out is cycle-aligned with cnt.
- period_tick = 1 exactly in the cycle where cnt = P-1. For P = 2 this is every other cycle.
- Stop: en = 0 finishes the current period. On the edge after the cnt = P-1 cycle, the block goes to IDLE with clk_out = 0 and cnt = 0. No truncated pulse is produced.
- Simultaneous en deassert and boundary: the block enters STOP_PEND, then one full further period runs before IDLE.
- rst mid-operation: everything returns to the reset values on the next edge. Pending config is discarded.
- cfg_valid held while cfg_ready = 0: nothing is captured. Upstream must hold cfg_valid until the transfer.

## Structure
- Package clk_pwm_pkg holds:
  - state enum (IDLE, RUN, STOP_PEND);
  - default CNT_W;
  - the clamp helper function for P and H.
- Single module with no sub-module. The pending/active register pair stays inline.

## Test plan
- Reset defaults: hold rst for 3 cycles, then en = 1. Required: a repeating pattern of clk_out high 3 / low 7 cycles, and period_tick every 10th cycle, aligned with the last low cycle.
- Live reconfig: while running, send cfg_period = 4, cfg_high = 2 at cnt = 5.
  - cfg_ready goes low.
  - The current 10-cycle period completes unchanged.
  - Then the pattern is high 2 / low 2.
  - cfg_ready returns to 1 one cycle after the switch.
- Clamp cases, each from IDLE:
  - cfg_period = 1 runs as P = 2 (alternating clk_out when H = 1).
  - cfg_high = 0 gives clk_out constant 0 with ticks still every P cycles.
  - cfg_high = 8 with cfg_period = 5 gives constant 1.
- Graceful stop: deassert en at cnt = 1 (P = 10, H = 3). Cycles continue to cnt = 9, then state is IDLE, busy = 0, clk_out stays 0. Reassert en mid-STOP_PEND: busy never drops and the count continues.
- Boundary-cycle capture: complete the handshake exactly in the period_tick cycle. The new values must apply only after one more full old period.
- Reset mid-run with a config pending: after rst, the pattern is back to 10/3, the pending config is lost, and cfg_ready = 1.
